// File: rtl/elevator_call_scheduler.sv
// Pending-call register and SCAN scheduler for the elevator FSM.
// Also runs the door-open dwell timer at each served stop.
module elevator_call_scheduler #(
    parameter int unsigned NUM_FLOORS  = 10,
    parameter logic [31:0] DOOR_CYCLES = 32'd20000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call_valid,
    input  logic [3:0]            call_floor,
    input  logic [3:0]            current_floor,
    input  logic                  car_idle,
    output logic [3:0]            target_floor,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned FW = 4;
    localparam int unsigned PW = 16;
    localparam int unsigned CW = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_DOOR  = 2'd2;

    logic [1:0]            state, state_n;
    logic [NUM_FLOORS-1:0] pending_n;
    logic [FW-1:0]         target_n;
    logic                  dir_n;
    logic                  door_n;
    logic [CW-1:0]         door_cnt, cnt_n;

    logic [PW-1:0]         pend_pad;
    logic [PW-1:0]         set_mask;
    logic [PW-1:0]         clr_mask;
    logic                  here_call;
    logic                  up_found, dn_found;
    logic [FW-1:0]         up_floor, dn_floor;

    // Nearest pending floor strictly above and strictly below the car
    always_comb begin
        pend_pad = PW'(pending);
        up_found = 1'b0;
        up_floor = '0;
        dn_found = 1'b0;
        dn_floor = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pend_pad[i] && (FW'(i) > current_floor)) begin
                up_found = 1'b1;
                up_floor = FW'(i);
            end
        end
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pend_pad[i] && (FW'(i) < current_floor)) begin
                dn_found = 1'b1;
                dn_floor = FW'(i);
            end
        end
    end

    // Next-state, call capture and scheduling decisions
    always_comb begin
        state_n   = state;
        target_n  = target_floor;
        dir_n     = dir_up;
        door_n    = door_open;
        cnt_n     = door_cnt;
        clr_mask  = '0;
        here_call = call_valid && (call_floor == current_floor) &&
                    ((state == ST_DOOR) || ((state == ST_IDLE) && car_idle));
        set_mask  = (call_valid && !here_call &&
                     ({1'b0, call_floor} < 5'(NUM_FLOORS))) ?
                    (PW'(1) << call_floor) : '0;

        case (state)
            ST_IDLE: begin
                target_n = current_floor;
                if (here_call) begin
                    state_n = ST_DOOR;
                    door_n  = 1'b1;
                    cnt_n   = DOOR_CYCLES - CW'(1);
                end else if (|pending) begin
                    dir_n   = up_found;
                    state_n = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (pending == '0) begin
                    state_n  = ST_IDLE;
                    target_n = current_floor;
                end else if (car_idle && (current_floor == target_floor) &&
                             pend_pad[target_floor]) begin
                    clr_mask = PW'(1) << target_floor;
                    door_n   = 1'b1;
                    cnt_n    = DOOR_CYCLES - CW'(1);
                    target_n = current_floor;
                    state_n  = ST_DOOR;
                end else if (dir_up) begin
                    if (up_found) begin
                        target_n = up_floor;
                    end else if (dn_found) begin
                        dir_n    = 1'b0;
                        target_n = dn_floor;
                    end else begin
                        target_n = current_floor;
                    end
                end else begin
                    if (dn_found) begin
                        target_n = dn_floor;
                    end else if (up_found) begin
                        dir_n    = 1'b1;
                        target_n = up_floor;
                    end else begin
                        target_n = current_floor;
                    end
                end
            end
            ST_DOOR: begin
                target_n = current_floor;
                if (here_call) begin
                    cnt_n = DOOR_CYCLES - CW'(1);
                end else if (door_cnt == '0) begin
                    door_n  = 1'b0;
                    state_n = (|pending) ? ST_SERVE : ST_IDLE;
                end else begin
                    cnt_n = door_cnt - CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                door_n  = 1'b0;
            end
        endcase

        // Clear wins over a same-cycle re-press of the floor being served
        pending_n = NUM_FLOORS'((pend_pad | set_mask) & ~clr_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pending      <= '0;
            target_floor <= '0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            door_cnt     <= '0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            target_floor <= target_n;
            dir_up       <= dir_n;
            door_open    <= door_n;
            door_cnt     <= cnt_n;
        end
    end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Collects floor call requests (buttons) into a pending-call register and schedules them with a SCAN policy. It drives the requested-floor input of the elevator state machine, watches the car's current floor and idle flag, and runs a door-open dwell timer at each served stop. It sits between the user inputs (ui_in) and the elevator FSM in the top level.

Parameters:
NUM_FLOORS, 10, number of served floors (1..16); floors 0..NUM_FLOORS-1
DOOR_CYCLES, 32'd20000000, clock cycles the door stays open per stop (bench uses 4)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
call_valid  input  1  one-cycle strobe: a call is presented on call_floor
call_floor  input  4  requested floor for call_valid
current_floor  input  4  car position from elevator FSM
car_idle  input  1  elevator FSM idle indication (1 = not moving)
target_floor  output  4  floor driven to the elevator FSM requested_floor input
dir_up  output  1  current sweep direction (1 = up, 0 = down)
door_open  output  1  high during door dwell
pending  output  NUM_FLOORS  registered pending-call bitmap, bit n = floor n

Behaviour:
- Reset (async, rst_n low): pending=0, state=IDLE, target_floor=0, dir_up=1, door_open=0, door counter=0.
- Call capture: call_valid with call_floor < NUM_FLOORS sets pending[call_floor] on the next edge; call_floor >= NUM_FLOORS is ignored. Re-press of a pending floor has no effect.
- Exception: call for current_floor while state is DOOR or (IDLE with car_idle) does not set pending; in DOOR it reloads the door counter; in IDLE it enters DOOR next cycle.
- States: IDLE, SERVE, DOOR.
- IDLE: target_floor = current_floor. If any pending bit set: choose direction (dir_up=1 if any pending above current_floor, else 0) and go SERVE.
- SERVE, dir_up=1: target_floor = lowest pending floor > current_floor. If none above: flip dir_up to 0, target = highest pending < current_floor. Symmetrical for dir_up=0 (highest below; else flip, lowest above). Target recomputed every cycle, so a new call ahead of the car in the sweep direction preempts the current target before it is reached.
- Arrival: in SERVE, car_idle=1 and current_floor==target_floor and pending[target_floor]=1 -> clear that bit, door_open=1, load counter, go DOOR (all on the same edge).
- DOOR: counter counts down to 0 over exactly DOOR_CYCLES cycles with door_open=1; target_floor held at current_floor. At expiry door_open=0, then SERVE if pending!=0 else IDLE.
- Simultaneous set and clear of the same bit: clear wins (call already being served).
- No pending bits in SERVE (cannot normally occur) -> IDLE.
- Registers only; all outputs registered; target_floor latency one cycle from pending/current_floor change.
- Reset mid-operation (any state, door open or moving): returns to reset values immediately; pending calls are lost.

Test Plan:
- Reset then call floor 3 at current_floor 0 -> pending=0x008 next cycle, SERVE, dir_up=1, target_floor=3; at current_floor=3, car_idle=1 -> pending=0, door_open high exactly 4 cycles, then IDLE with target_floor=3.
- Car moving up at floor 2 toward 7, call floor 5 -> target_floor changes to 5 next cycle; after stop at 5 and door dwell, target_floor=7.
- Car at 6 going up, pending {2,8}, serve 8 -> dir_up flips to 0, target_floor=2.
- Call current floor while idle at 4 -> no pending bit, door_open for 4 cycles; repeat press during dwell -> dwell restarts (8 total cycles with one press at cycle 4).
- call_floor=12 with NUM_FLOORS=10 -> pending unchanged, state stays IDLE.
- Assert rst_n low during DOOR with pending {1,9} -> pending=0, door_open=0, target_floor=0, dir_up=1 asynchronously.
